// File: rtl/de_pipe_reg.sv
// de_pipe_reg: decode-to-execute stage register.
// Action priority each edge: reset > flush > hold > stall (bubble) > load.
// A bubble clears the instruction identity but keeps PC+8/BD so a later
// exception on the empty slot can still report a correct EPC.
// bubble_cnt counts bubbles actually inserted and saturates at all-ones.
module de_pipe_reg #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5,
   parameter int RES_W  = 2,
   parameter int EXC_W  = 5,
   parameter int BCNT_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              hold,
   input  logic              stall,
   input  logic              cnt_clr,
   input  logic [XLEN-1:0]   ir_d,
   input  logic [XLEN-1:0]   pc8_d,
   input  logic [XLEN-1:0]   rs_d,
   input  logic [XLEN-1:0]   rt_d,
   input  logic [XLEN-1:0]   ext_d,
   input  logic [REG_AW-1:0] a3_d,
   input  logic [RES_W-1:0]  res_d,
   input  logic [EXC_W-1:0]  exc_d,
   input  logic              bd_d,
   input  logic              valid_d,
   output logic [XLEN-1:0]   ir_e,
   output logic [XLEN-1:0]   pc8_e,
   output logic [XLEN-1:0]   rs_e,
   output logic [XLEN-1:0]   rt_e,
   output logic [XLEN-1:0]   ext_e,
   output logic [REG_AW-1:0] a3_e,
   output logic [RES_W-1:0]  res_e,
   output logic [EXC_W-1:0]  exc_e,
   output logic              bd_e,
   output logic              valid_e,
   output logic [BCNT_W-1:0] bubble_cnt
);

   // Stage payload carried from D to E.
   typedef struct packed {
      logic [XLEN-1:0]   ir;
      logic [XLEN-1:0]   pc8;
      logic [XLEN-1:0]   rs;
      logic [XLEN-1:0]   rt;
      logic [XLEN-1:0]   ext;
      logic [REG_AW-1:0] a3;
      logic [RES_W-1:0]  res;
      logic [EXC_W-1:0]  exc;
      logic              bd;
      logic              valid;
   } de_t;

   de_t d_in;
   de_t e_q;
   de_t e_nxt;
   logic bubble_take;

   // Gather the D-stage inputs into one payload.
   always_comb begin
      d_in       = '0;
      d_in.ir    = ir_d;
      d_in.pc8   = pc8_d;
      d_in.rs    = rs_d;
      d_in.rt    = rt_d;
      d_in.ext   = ext_d;
      d_in.a3    = a3_d;
      d_in.res   = res_d;
      d_in.exc   = exc_d;
      d_in.bd    = bd_d;
      d_in.valid = valid_d;
   end

   // A bubble is only inserted (and counted) when neither flush nor hold wins.
   assign bubble_take = stall & ~flush & ~hold;

   // Next stage contents by priority flush > hold > stall > load.
   always_comb begin
      e_nxt = e_q;
      if (flush) begin
         e_nxt = '0;
      end else if (hold) begin
         e_nxt = e_q;
      end else if (stall) begin
         // rs/rt/ext keep their old values; only identity is cleared.
         e_nxt.ir    = '0;
         e_nxt.a3    = '0;
         e_nxt.res   = '0;
         e_nxt.exc   = '0;
         e_nxt.valid = 1'b0;
         e_nxt.pc8   = d_in.pc8;
         e_nxt.bd    = d_in.bd;
      end else begin
         e_nxt = d_in;
      end
   end

   // Stage register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) e_q <= '0;
      else        e_q <= e_nxt;
   end

   // Saturating bubble counter; clear wins over an increment.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                               bubble_cnt <= '0;
      else if (cnt_clr)                         bubble_cnt <= '0;
      else if (bubble_take && bubble_cnt != '1) bubble_cnt <= bubble_cnt + BCNT_W'(1);
   end

   assign ir_e    = e_q.ir;
   assign pc8_e   = e_q.pc8;
   assign rs_e    = e_q.rs;
   assign rt_e    = e_q.rt;
   assign ext_e   = e_q.ext;
   assign a3_e    = e_q.a3;
   assign res_e   = e_q.res;
   assign exc_e   = e_q.exc;
   assign bd_e    = e_q.bd;
   assign valid_e = e_q.valid;

endmodule
